// File: rtl/riscv_pkg.sv
// Shared fetch-path types: data width, fetch FSM states and the prefetch buffer entry.
package riscv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: DEPTH-entry FIFO with simultaneous push/pop and a flush that wins over both.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  fetch_entry_t push_data_i,
  output fetch_entry_t head_o,
  output logic [CW-1:0] count_o
);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  // A full buffer still takes a push when the head leaves in the same cycle.
  assign do_pop  = pop_i && (count_q != '0) && !flush_i;
  assign do_push = push_i && ((count_q < CW'(DEPTH)) || do_pop) && !flush_i;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: single-outstanding memory requests into a prefetch buffer, with redirect flush.
// Define FETCH_PERF_CNT_EN to add the perf_fetch_cnt / perf_flush_cnt counter outputs.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            inst_ready
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetch_cnt,
  output logic [31:0]     perf_flush_cnt
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] redirect_tgt, pc_plus4;
  logic [CW-1:0]   count, count_post;
  logic            push, pop;
  fetch_entry_t    head;

  assign redirect_tgt = align_word(redirect_pc);
  assign pc_plus4     = fetch_pc_q + XLEN'(4);
  assign push         = (state_q == REQ) && imem_ack && !redirect;
  assign pop          = inst_valid && inst_ready;
  assign count_post   = count + CW'(push) - CW'(pop);

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .pop_i       (pop),
    .flush_i     (redirect),
    .push_data_i ('{pc: fetch_pc_q, inst: imem_rdata}),
    .head_o      (head),
    .count_o     (count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    case (state_q)
      IDLE: begin
        if (redirect) begin
          state_d    = REQ;
          fetch_pc_d = redirect_tgt;
          addr_d     = redirect_tgt;
        end else if (count < CW'(DEPTH)) begin
          state_d = REQ;
          addr_d  = fetch_pc_q;
        end
      end
      REQ: begin
        if (redirect) begin
          fetch_pc_d = redirect_tgt;
          if (imem_ack) addr_d  = redirect_tgt;
          else          state_d = DISCARD;
        end else if (imem_ack) begin
          fetch_pc_d = pc_plus4;
          if (count_post < CW'(DEPTH)) addr_d  = pc_plus4;
          else                         state_d = IDLE;
        end
      end
      DISCARD: begin
        // The in-flight word belongs to the old stream; only the target moves until it returns.
        if (redirect) fetch_pc_d = redirect_tgt;
        if (imem_ack) begin
          state_d = REQ;
          addr_d  = redirect ? redirect_tgt : fetch_pc_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    imem_req   = (state_q == REQ) || (state_q == DISCARD);
    imem_addr  = addr_q;
    inst_valid = (count != '0) && !redirect;
    inst       = head.inst;
    inst_pc    = head.pc;
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (push)     fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (redirect) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: scoreboard of expected {pc, inst} against consumed heads.
module tb_fetch_unit;

  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst, imem_req, imem_ack, redirect, inst_valid, inst_ready;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, inst, inst_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt, perf_flush_cnt;
`endif

  int          chk_cnt  = 0;
  int          pass_cnt = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ~a ^ 32'h1357_9BDF;
  endfunction

  assign imem_rdata = imem_ack ? mem_word(imem_addr) : 32'hDEAD_BEEF;

  fetch_unit #(.RESET_PC(RPC), .DEPTH(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_ready  (inst_ready)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  task automatic pulse_reset(input logic ack, input logic ready);
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0;
    imem_ack = ack; inst_ready = ready;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; imem_ack = 1'b0; inst_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    chk_cnt++; if (imem_req !== 1'b0) $display("FAIL reset_req: got %b expected 0", imem_req); else pass_cnt++;
    chk_cnt++; if (inst_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", inst_valid); else pass_cnt++;
    chk_cnt++; if (imem_addr !== RPC) $display("FAIL reset_addr: got %h expected %h", imem_addr, RPC); else pass_cnt++;
    rst = 1'b0;
    @(negedge clk);
    chk_cnt++; if (imem_req !== 1'b1 || imem_addr !== RPC)
      $display("FAIL first_req: req %b addr %h expected 1 %h", imem_req, imem_addr, RPC); else pass_cnt++;
    $display("test_reset done");
  endtask

  task automatic test_stream();
    logic [31:0] e;
    int cyc = 0, first = -1, gaps = 0;
    pulse_reset(1'b1, 1'b1);
    for (int i = 0; i < 8; i++) exp_q.push_back(RPC + 32'(4 * i));
    for (int c = 0; c < 40 && exp_q.size() != 0; c++) begin
      if (inst_valid) begin
        if (first < 0) first = cyc;
        e = exp_q.pop_front();
        chk_cnt++; if (inst_pc !== e || inst !== mem_word(e))
          $display("FAIL stream_head: pc %h inst %h expected pc %h inst %h", inst_pc, inst, e, mem_word(e));
        else pass_cnt++;
      end else if (first >= 0) gaps++;
      @(negedge clk); cyc++;
    end
    chk_cnt++; if (exp_q.size() != 0) $display("FAIL stream_timeout: %0d left expected 0", exp_q.size()); else pass_cnt++;
    chk_cnt++; if (first != 2) $display("FAIL stream_latency: first valid at cycle %0d expected 2", first); else pass_cnt++;
    chk_cnt++; if (gaps != 0) $display("FAIL stream_rate: %0d bubbles expected 0", gaps); else pass_cnt++;
    $display("test_stream done: first=%0d gaps=%0d", first, gaps);
  endtask

  task automatic test_backpressure();
    logic [31:0] e;
    logic [31:0] resume_addr = '0;
    logic        resumed = 1'b0;
    int pushes = 0;
    pulse_reset(1'b1, 1'b0);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (imem_req && imem_ack) pushes++;
    end
    chk_cnt++; if (pushes != 2) $display("FAIL bp_pushes: got %0d expected 2", pushes); else pass_cnt++;
    chk_cnt++; if (imem_req !== 1'b0) $display("FAIL bp_idle: req %b expected 0", imem_req); else pass_cnt++;
    chk_cnt++; if (inst_valid !== 1'b1 || inst_pc !== RPC)
      $display("FAIL bp_head: valid %b pc %h expected 1 %h", inst_valid, inst_pc, RPC); else pass_cnt++;
    inst_ready = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back(RPC + 32'(4 * i));
    for (int c = 0; c < 40 && exp_q.size() != 0; c++) begin
      if (imem_req && !resumed) begin resumed = 1'b1; resume_addr = imem_addr; end
      if (inst_valid) begin
        e = exp_q.pop_front();
        chk_cnt++; if (inst_pc !== e || inst !== mem_word(e))
          $display("FAIL bp_head_seq: pc %h inst %h expected pc %h inst %h", inst_pc, inst, e, mem_word(e));
        else pass_cnt++;
      end
      @(negedge clk);
    end
    chk_cnt++; if (exp_q.size() != 0) $display("FAIL bp_timeout: %0d left expected 0", exp_q.size()); else pass_cnt++;
    chk_cnt++; if (resume_addr !== 32'h108) $display("FAIL bp_resume_addr: got %h expected 00000108", resume_addr); else pass_cnt++;
    $display("test_backpressure done: pushes=%0d resume=%h", pushes, resume_addr);
  endtask

  task automatic test_redirect_wait();
    logic [31:0] e;
    pulse_reset(1'b0, 1'b1);
    @(negedge clk);
    chk_cnt++; if (imem_req !== 1'b1 || imem_addr !== RPC)
      $display("FAIL rw_pre: req %b addr %h expected 1 %h", imem_req, imem_addr, RPC); else pass_cnt++;
    redirect = 1'b1; redirect_pc = 32'h0000_2003;
    @(negedge clk);
    redirect = 1'b0;
    chk_cnt++; if (imem_req !== 1'b1 || imem_addr !== RPC)
      $display("FAIL rw_discard_hold: req %b addr %h expected 1 %h", imem_req, imem_addr, RPC); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if (imem_addr !== RPC) $display("FAIL rw_discard_hold2: addr %h expected %h", imem_addr, RPC); else pass_cnt++;
    imem_ack = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    chk_cnt++; if (imem_req !== 1'b1 || imem_addr !== 32'h2000)
      $display("FAIL rw_new_req: req %b addr %h expected 1 00002000", imem_req, imem_addr); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if (inst_valid !== 1'b0) $display("FAIL rw_dropped: valid %b expected 0", inst_valid); else pass_cnt++;
    imem_ack = 1'b1;
    for (int i = 0; i < 3; i++) exp_q.push_back(32'h2000 + 32'(4 * i));
    for (int c = 0; c < 40 && exp_q.size() != 0; c++) begin
      if (inst_valid) begin
        e = exp_q.pop_front();
        chk_cnt++; if (inst_pc !== e || inst !== mem_word(e))
          $display("FAIL rw_head: pc %h inst %h expected pc %h inst %h", inst_pc, inst, e, mem_word(e));
        else pass_cnt++;
      end
      @(negedge clk);
    end
    chk_cnt++; if (exp_q.size() != 0) $display("FAIL rw_timeout: %0d left expected 0", exp_q.size()); else pass_cnt++;
    $display("test_redirect_wait done");
  endtask

  task automatic test_redirect_ack();
    logic [31:0] e;
    pulse_reset(1'b1, 1'b1);
    exp_q.push_back(RPC); exp_q.push_back(RPC + 32'h4);
    for (int c = 0; c < 40 && exp_q.size() != 0; c++) begin
      if (inst_valid) begin
        e = exp_q.pop_front();
        chk_cnt++; if (inst_pc !== e) $display("FAIL ra_pre_head: pc %h expected %h", inst_pc, e); else pass_cnt++;
      end
      @(negedge clk);
    end
    chk_cnt++; if (inst_valid !== 1'b1 || imem_req !== 1'b1)
      $display("FAIL ra_pre_state: valid %b req %b expected 1 1", inst_valid, imem_req); else pass_cnt++;
    redirect = 1'b1; redirect_pc = 32'h0000_3000;
    #1;
    chk_cnt++; if (inst_valid !== 1'b0) $display("FAIL ra_valid_masked: valid %b expected 0", inst_valid); else pass_cnt++;
    @(negedge clk);
    redirect = 1'b0;
    chk_cnt++; if (inst_valid !== 1'b0 || imem_addr !== 32'h3000 || imem_req !== 1'b1)
      $display("FAIL ra_after: valid %b addr %h req %b expected 0 00003000 1", inst_valid, imem_addr, imem_req);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) exp_q.push_back(32'h3000 + 32'(4 * i));
    for (int c = 0; c < 40 && exp_q.size() != 0; c++) begin
      if (inst_valid) begin
        e = exp_q.pop_front();
        chk_cnt++; if (inst_pc !== e || inst !== mem_word(e))
          $display("FAIL ra_head: pc %h inst %h expected pc %h inst %h", inst_pc, inst, e, mem_word(e));
        else pass_cnt++;
      end
      @(negedge clk);
    end
    chk_cnt++; if (exp_q.size() != 0) $display("FAIL ra_timeout: %0d left expected 0", exp_q.size()); else pass_cnt++;
    $display("test_redirect_ack done");
  endtask

  task automatic test_reset_mid();
    logic [31:0] e;
    pulse_reset(1'b0, 1'b1);
    @(negedge clk); @(negedge clk);
    chk_cnt++; if (imem_req !== 1'b1) $display("FAIL rm_pre: req %b expected 1", imem_req); else pass_cnt++;
    #2 rst = 1'b1;
    #1;
    chk_cnt++; if (imem_req !== 1'b0 || inst_valid !== 1'b0)
      $display("FAIL rm_async: req %b valid %b expected 0 0", imem_req, inst_valid); else pass_cnt++;
`ifdef FETCH_PERF_CNT_EN
    chk_cnt++; if (perf_fetch_cnt !== 32'd0 || perf_flush_cnt !== 32'd0)
      $display("FAIL rm_perf: fetch %0d flush %0d expected 0 0", perf_fetch_cnt, perf_flush_cnt); else pass_cnt++;
`endif
    @(negedge clk);
    imem_ack = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) exp_q.push_back(RPC + 32'(4 * i));
    for (int c = 0; c < 40 && exp_q.size() != 0; c++) begin
      if (inst_valid) begin
        e = exp_q.pop_front();
        chk_cnt++; if (inst_pc !== e || inst !== mem_word(e))
          $display("FAIL rm_head: pc %h inst %h expected pc %h inst %h", inst_pc, inst, e, mem_word(e));
        else pass_cnt++;
      end
      @(negedge clk);
    end
    chk_cnt++; if (exp_q.size() != 0) $display("FAIL rm_timeout: %0d left expected 0", exp_q.size()); else pass_cnt++;
    $display("test_reset_mid done");
  endtask

  initial begin
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; imem_ack = 1'b0; inst_ready = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_wait();
    test_redirect_ack();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
